imem_bank: RTL and testbench
============================

IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 SHALL have parameter BYTE_ADDR_WIDTH, default 6, byte-address width; depth = 2**(BYTE_ADDR_WIDTH-2) words (16).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_ctrl  input  1  1 = UART loader owns memory, 0 = CPU owns.
REQ-005 SHALL have port imem_wr_en  input  1  loader write strobe.
REQ-006 SHALL have port imem_addr  input  BYTE_ADDR_WIDTH-2  loader word address.
REQ-007 SHALL have port imem_byte_en  input  4  loader byte lane enables, bit i = bits 8i+7:8i.
REQ-008 SHALL have port imem_wr_data  input  32  loader write data.
REQ-009 SHALL have port cpu_rd_en  input  1  CPU fetch request.
REQ-010 SHALL have port cpu_addr  input  BYTE_ADDR_WIDTH-2  CPU fetch word address.
REQ-011 SHALL have port cpu_rd_data  output  32  fetched instruction.
REQ-012 SHALL have port cpu_rd_valid  output  1  cpu_rd_data valid this cycle.
REQ-013 SHALL have port words_loaded  output  BYTE_ADDR_WIDTH-1  count of fully written words.
REQ-014 SHALL have port imem_chk  output  32  load checksum (see Configuration).

Function
REQ-015 Writes SHALL occur only when imem_ctrl=1 and imem_wr_en=1; each enabled byte lane written at imem_addr; disabled lanes unchanged.
REQ-016 SHALL keep one valid bit per byte (4 per word); a write sets the valid bits of its enabled lanes.
REQ-017 A word is "loaded" when all 4 valid bits are set; words_loaded SHALL be the combinational popcount of loaded words, range 0..depth.
REQ-018 On the cycle after imem_ctrl rises 0->1 (registered edge detect), all valid bits SHALL clear; a write in that same first cycle SHALL take effect and set its valid bits (write wins over clear for its lanes).
REQ-019 Fetch SHALL be honoured only when imem_ctrl=0 and cpu_rd_en=1; cpu_rd_valid SHALL assert exactly one cycle later, one-cycle latency, back-to-back fetches every cycle allowed.
REQ-020 Fetched data SHALL be the stored word if loaded, else NOP 32'h0000_0013 (partially written words return NOP).
REQ-021 With imem_ctrl=1, cpu_rd_en SHALL be ignored: cpu_rd_valid=0, cpu_rd_data holds last value.
REQ-022 With imem_ctrl=0, imem_wr_en SHALL be ignored; memory, valid bits, checksum unchanged.
REQ-023 Fetch and imem_ctrl rising in same cycle: fetch SHALL be dropped (ctrl value of that cycle governs).
REQ-024 Address arithmetic SHALL be unsigned; addresses are full-range, no wrap/out-of-range case exists.

Reset
REQ-025 rst_n low SHALL immediately clear all valid bits, cpu_rd_valid=0, cpu_rd_data=NOP, imem_chk=0, edge-detect register=0.
REQ-026 Memory array contents SHALL NOT be reset; reset during load SHALL discard all progress (words_loaded=0).

Configuration
REQ-027 With IMEM_CHECKSUM_EN defined, imem_chk SHALL be the XOR of (imem_wr_data AND lane mask) over all accepted writes since last load-mode entry or reset, cleared with valid bits per REQ-018.
REQ-028 Without IMEM_CHECKSUM_EN, imem_chk SHALL be constant 0 and no checksum register SHALL exist.

Structure
REQ-029 Package imem_pkg SHALL hold NOP constant 32'h0000_0013, WORD_BYTES=4, typedef word_t (32-bit logic).
REQ-030 Valid-bit storage, clear, and popcount SHALL live in sub-module imem_valid_tracker; array and fetch path in imem_bank.

Verification
REQ-031 Reset, ctrl=0, fetch addr 0 -> next cycle valid=1, data 0000_0013, words_loaded=0.
REQ-032 ctrl=1, write addr 3 data DEADBEEF be=1111, ctrl=0, fetch 3 -> DEADBEEF one cycle later, words_loaded=1.
REQ-033 Write addr 5 be=0011 then be=1100 data 12345678 each -> words_loaded +1 after second write only; fetch returns 12345678; after first only fetch returns NOP.
REQ-034 Load 16 words, ctrl 1->0->1 -> words_loaded 16 then 0; fetch every word returns NOP until rewritten.
REQ-035 ctrl=0 with wr_en=1 addr 2 data 0 -> fetch 2 unchanged; ctrl=1 with cpu_rd_en=1 -> cpu_rd_valid stays 0.
REQ-036 IMEM_CHECKSUM_EN: writes 0000_00FF be=0001 and FFFF_FF00 be=0010 -> imem_chk=0000_FFFF; without macro -> 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory bank.
// Builds with or without IMEM_CHECKSUM_EN; no package content depends on it.
package imem_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

    // RISC-V "addi x0, x0, 0"; returned for any word that is not fully loaded.
    localparam word_t NOP = 32'h0000_0013;

    function automatic word_t lane_mask(input logic [WORD_BYTES-1:0] be);
        word_t m;
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/imem_bank_if.sv
// Loader write port, CPU fetch port and load-status outputs of imem_bank.
// Shared by both builds (IMEM_CHECKSUM_EN only changes what drives imem_chk).
interface imem_bank_if
    import imem_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6
);

    localparam int AW = BYTE_ADDR_WIDTH - 2;

    // The loader owns the array while imem_ctrl=1 and writes whenever
    // imem_wr_en=1 (no back-pressure). The CPU owns it while imem_ctrl=0; a
    // cycle with cpu_rd_en=1 is a fetch, answered exactly one cycle later by
    // cpu_rd_valid=1 with cpu_rd_data; there is no ready, one fetch per cycle.
    logic                  imem_ctrl;
    logic                  imem_wr_en;
    logic [AW-1:0]         imem_addr;
    logic [WORD_BYTES-1:0] imem_byte_en;
    word_t                 imem_wr_data;
    logic                  cpu_rd_en;
    logic [AW-1:0]         cpu_addr;
    word_t                 cpu_rd_data;
    logic                  cpu_rd_valid;
    logic [AW:0]           words_loaded;
    word_t                 imem_chk;

    modport master (
        output imem_ctrl, imem_wr_en, imem_addr, imem_byte_en, imem_wr_data,
        output cpu_rd_en, cpu_addr,
        input  cpu_rd_data, cpu_rd_valid, words_loaded, imem_chk
    );

    modport slave (
        input  imem_ctrl, imem_wr_en, imem_addr, imem_byte_en, imem_wr_data,
        input  cpu_rd_en, cpu_addr,
        output cpu_rd_data, cpu_rd_valid, words_loaded, imem_chk
    );

endinterface

// File: rtl/imem_valid_tracker.sv
// Per-byte valid bits for the instruction array, bulk clear on load entry,
// and the popcount of fully written words.
module imem_valid_tracker
    import imem_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  wr_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [WORD_BYTES-1:0] byte_en_i,
    output logic [(1<<AW)-1:0]    loaded_o,
    output logic [AW:0]           words_loaded_o
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [WORD_BYTES-1:0] valid_q [DEPTH];
    logic [WORD_BYTES-1:0] valid_d [DEPTH];
    logic [CW-1:0]         count;

    // Clear is applied first so a write in the entry cycle keeps its lanes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = clear_i ? '0 : valid_q[i];
        end
        if (wr_i) begin
            valid_d[wr_addr_i] = valid_d[wr_addr_i] | byte_en_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            loaded_o[i] = &valid_q[i];
            count       = count + CW'(loaded_o[i]);
        end
    end

    assign words_loaded_o = count;

endmodule

// File: rtl/imem_bank.sv
// Instruction memory shared between a UART loader and the CPU fetch port.
// Optional load checksum on imem_chk when IMEM_CHECKSUM_EN is defined.
module imem_bank
    import imem_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_bank_if.slave  bus
);

    localparam int AW    = BYTE_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << AW;

    word_t             mem_q [DEPTH];
    logic              ctrl_q, ctrl_d;
    logic              rd_valid_q, rd_valid_d;
    word_t             rd_data_q, rd_data_d;
    logic              load_entry;
    logic              wr_accept;
    logic              rd_fire;
    logic [DEPTH-1:0]  loaded;

    // First cycle of a load session: ctrl is high now but was low last cycle.
    assign load_entry = bus.imem_ctrl & ~ctrl_q;
    assign wr_accept  = bus.imem_ctrl & bus.imem_wr_en;
    assign rd_fire    = ~bus.imem_ctrl & bus.cpu_rd_en;

    imem_valid_tracker #(
        .AW (AW)
    ) u_valid (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (load_entry),
        .wr_i           (wr_accept),
        .wr_addr_i      (bus.imem_addr),
        .byte_en_i      (bus.imem_byte_en),
        .loaded_o       (loaded),
        .words_loaded_o (bus.words_loaded)
    );

    // Array contents survive reset; only the valid bits decide what is fetchable.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (bus.imem_byte_en[i]) begin
                    mem_q[bus.imem_addr][8*i +: 8] <= bus.imem_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ctrl_d     = bus.imem_ctrl;
        rd_valid_d = rd_fire;
        rd_data_d  = rd_data_q;
        if (rd_fire) begin
            rd_data_d = loaded[bus.cpu_addr] ? mem_q[bus.cpu_addr] : NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= NOP;
        end else begin
            ctrl_q     <= ctrl_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.cpu_rd_valid = rd_valid_q;
    assign bus.cpu_rd_data  = rd_data_q;

`ifdef IMEM_CHECKSUM_EN
    word_t chk_q, chk_d;

    always_comb begin
        chk_d = load_entry ? '0 : chk_q;
        if (wr_accept) begin
            chk_d = chk_d ^ (bus.imem_wr_data & lane_mask(bus.imem_byte_en));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign bus.imem_chk = chk_q;
`else
    assign bus.imem_chk = '0;
`endif

endmodule

// File: tb/tb_imem_bank.sv
// Directed bench for imem_bank; expected checksum follows IMEM_CHECKSUM_EN.
module tb_imem_bank;
    import imem_pkg::*;

    localparam int BAW = 6;

    logic clk;
    logic rst_n;
    int   total_cnt  = 0;
    int   passed_cnt = 0;

    imem_bank_if #(.BYTE_ADDR_WIDTH(BAW)) bus ();

    imem_bank #(.BYTE_ADDR_WIDTH(BAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_chk(input logic [31:0] v);
`ifdef IMEM_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203) ^ 32'h0000_0040;
    endfunction

    // driver tasks
    task automatic set_ctrl(input logic c);
        bus.imem_ctrl = c;
        tick();
    endtask

    task automatic load_write(input int addr, input logic [3:0] be, input logic [31:0] data);
        bus.imem_wr_en   = 1'b1;
        bus.imem_addr    = 4'(addr);
        bus.imem_byte_en = be;
        bus.imem_wr_data = data;
        tick();
        bus.imem_wr_en   = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input int addr, input logic [31:0] exp);
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 4'(addr);
        tick();
        bus.cpu_rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus.cpu_rd_valid), 32'd1);
        chk({tag, "_data"}, bus.cpu_rd_data, exp);
    endtask

    task automatic words_chk(input string tag, input int exp);
        chk(tag, 32'(bus.words_loaded), 32'(exp));
    endtask

    logic [31:0] acc;

    initial begin
        rst_n            = 1'b0;
        bus.imem_ctrl    = 1'b0;
        bus.imem_wr_en   = 1'b0;
        bus.imem_addr    = '0;
        bus.imem_byte_en = '0;
        bus.imem_wr_data = '0;
        bus.cpu_rd_en    = 1'b0;
        bus.cpu_addr     = '0;
        repeat (2) tick();

        chk("rst_valid", 32'(bus.cpu_rd_valid), 32'd0);
        chk("rst_data", bus.cpu_rd_data, 32'h0000_0013);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        chk("rst_chk", bus.imem_chk, 32'h0);
        rst_n = 1'b1;
        tick();

        // empty memory fetches NOP, valid pulses for one cycle only
        fetch_chk("empty0", 0, 32'h0000_0013);
        words_chk("empty_words", 0);
        tick();
        chk("valid_drop", 32'(bus.cpu_rd_valid), 32'd0);
        chk("data_hold", bus.cpu_rd_data, 32'h0000_0013);

        // full word load then fetch
        set_ctrl(1'b1);
        load_write(3, 4'b1111, 32'hDEAD_BEEF);
        words_chk("w3_words", 1);
        chk("w3_chk", bus.imem_chk, exp_chk(32'hDEAD_BEEF));
        set_ctrl(1'b0);
        fetch_chk("f3", 3, 32'hDEAD_BEEF);
        words_chk("f3_words", 1);

        // half-written word reads as NOP; re-entry invalidated word 3
        set_ctrl(1'b1);
        words_chk("reentry_words", 0);
        chk("reentry_chk", bus.imem_chk, 32'h0);
        load_write(5, 4'b0011, 32'h1234_5678);
        words_chk("half_words", 0);
        chk("half_chk", bus.imem_chk, exp_chk(32'h0000_5678));
        set_ctrl(1'b0);
        fetch_chk("half5", 5, 32'h0000_0013);
        fetch_chk("stale3", 3, 32'h0000_0013);

        // two halves complete the word
        set_ctrl(1'b1);
        load_write(5, 4'b0011, 32'h1234_5678);
        words_chk("lo_words", 0);
        load_write(5, 4'b1100, 32'h1234_5678);
        words_chk("hi_words", 1);
        chk("hilo_chk", bus.imem_chk, exp_chk(32'h1234_5678));
        set_ctrl(1'b0);
        fetch_chk("full5", 5, 32'h1234_5678);

        // entry cycle: write wins over clear, simultaneous fetch is dropped
        bus.imem_ctrl    = 1'b1;
        bus.cpu_rd_en    = 1'b1;
        bus.cpu_addr     = 4'd5;
        bus.imem_wr_en   = 1'b1;
        bus.imem_addr    = 4'd7;
        bus.imem_byte_en = 4'b1111;
        bus.imem_wr_data = 32'hCAFE_F00D;
        tick();
        bus.cpu_rd_en  = 1'b0;
        bus.imem_wr_en = 1'b0;
        chk("entry_drop_valid", 32'(bus.cpu_rd_valid), 32'd0);
        chk("entry_drop_data", bus.cpu_rd_data, 32'h1234_5678);
        words_chk("entry_wr_words", 1);
        chk("entry_wr_chk", bus.imem_chk, exp_chk(32'hCAFE_F00D));

        // fill all 16 words
        acc = 32'hCAFE_F00D;
        for (int i = 0; i < 16; i++) begin
            load_write(i, 4'b1111, pat(i));
            acc = acc ^ pat(i);
        end
        words_chk("fill_words", 16);
        chk("fill_chk", bus.imem_chk, exp_chk(acc));

        // fetch while loader owns memory is ignored
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 4'd0;
        tick();
        bus.cpu_rd_en = 1'b0;
        chk("own_valid", 32'(bus.cpu_rd_valid), 32'd0);
        chk("own_data", bus.cpu_rd_data, 32'h1234_5678);

        // write while CPU owns memory is ignored
        set_ctrl(1'b0);
        words_chk("cpu_words", 16);
        load_write(2, 4'b1111, 32'h0);
        words_chk("ign_words", 16);
        chk("ign_chk", bus.imem_chk, exp_chk(acc));
        fetch_chk("ign2", 2, pat(2));

        // back-to-back fetch of every word
        bus.cpu_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.cpu_addr = 4'(i);
            tick();
            chk($sformatf("b2b_valid%0d", i), 32'(bus.cpu_rd_valid), 32'd1);
            chk($sformatf("b2b_data%0d", i), bus.cpu_rd_data, pat(i));
        end
        bus.cpu_rd_en = 1'b0;

        // reload cycle invalidates everything
        set_ctrl(1'b1);
        words_chk("clr_words", 0);
        set_ctrl(1'b0);
        bus.cpu_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.cpu_addr = 4'(i);
            tick();
            chk($sformatf("nop_data%0d", i), bus.cpu_rd_data, 32'h0000_0013);
        end
        bus.cpu_rd_en = 1'b0;

        set_ctrl(1'b1);
        load_write(9, 4'b1111, pat(9));
        set_ctrl(1'b0);
        fetch_chk("rew8", 8, 32'h0000_0013);
        fetch_chk("rew9", 9, pat(9));

        // masked checksum lanes
        set_ctrl(1'b1);
        chk("mask_chk0", bus.imem_chk, 32'h0);
        load_write(0, 4'b0001, 32'h0000_00FF);
        load_write(0, 4'b0010, 32'hFFFF_FF00);
        chk("mask_chk", bus.imem_chk, exp_chk(32'h0000_FFFF));
        words_chk("mask_words", 0);

        // asynchronous reset mid-load discards progress
        load_write(1, 4'b1111, 32'h7777_8888);
        words_chk("prerst_words", 1);
        #3;
        rst_n = 1'b0;
        #1;
        words_chk("arst_words", 0);
        chk("arst_chk", bus.imem_chk, 32'h0);
        chk("arst_data", bus.cpu_rd_data, 32'h0000_0013);
        tick();
        rst_n = 1'b1;
        set_ctrl(1'b0);
        fetch_chk("post_rst1", 1, 32'h0000_0013);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
